// File: rtl/stream_downsizer.sv
`default_nettype none
// ============================================================================
// stream_downsizer
//   Splits each DW*SCALE-bit input word into SCALE DW-bit beats, LSB first.
//   Revision: 1.0
// ============================================================================
module stream_downsizer #(
  parameter int DW    = 8,
  parameter int SCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW*SCALE-1:0]   s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DW-1:0]         m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o
);

  localparam int            CW        = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(SCALE - 1);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW*SCALE-1:0] word_q, word_d;
  logic                in_xfer;
  logic                out_xfer;

  assign m_valid_o = (state_q == HOLD);
  assign m_last_o  = (state_q == HOLD) && (cnt_q == LAST_BEAT);
  // rst gates ready directly so the source sees it drop without a clock edge
  assign s_ready_o = !rst && ((state_q == EMPTY) || (m_last_o && m_ready_i));

  assign in_xfer  = s_valid_i && s_ready_o;
  assign out_xfer = m_valid_o && m_ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    if (in_xfer) begin
      // Covers both the EMPTY fill and the reload on the final beat
      state_d = HOLD;
      cnt_d   = '0;
      word_d  = s_data_i;
    end else if (out_xfer) begin
      if (m_last_o) begin
        state_d = EMPTY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  generate
    if (SCALE == 1) begin : g_single
      assign m_data_o = word_q;
    end else begin : g_multi
      logic [DW-1:0] beats [SCALE];
      for (genvar k = 0; k < SCALE; k++) begin : g_beat
        assign beats[k] = word_q[k*DW +: DW];
      end
      assign m_data_o = beats[cnt_q];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_stream_downsizer.sv
`default_nettype none
// ============================================================================
// tb_stream_downsizer
//   Directed checks of the 8x4 downsizer plus a 32x1 register-slice instance.
//   Revision: 1.0
// ============================================================================
module tb_stream_downsizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] a_s_data  = '0;
  logic        a_s_valid = 1'b0;
  logic        a_s_ready;
  logic [7:0]  a_m_data;
  logic        a_m_valid;
  logic        a_m_ready = 1'b0;
  logic        a_m_last;

  logic [31:0] b_s_data  = '0;
  logic        b_s_valid = 1'b0;
  logic        b_s_ready;
  logic [31:0] b_m_data;
  logic        b_m_valid;
  logic        b_m_ready = 1'b0;
  logic        b_m_last;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_downsizer #(.DW(8), .SCALE(4)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (a_s_data),
    .s_valid_i (a_s_valid),
    .s_ready_o (a_s_ready),
    .m_data_o  (a_m_data),
    .m_valid_o (a_m_valid),
    .m_ready_i (a_m_ready),
    .m_last_o  (a_m_last)
  );

  stream_downsizer #(.DW(32), .SCALE(1)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (b_s_data),
    .s_valid_i (b_s_valid),
    .s_ready_o (b_s_ready),
    .m_data_o  (b_m_data),
    .m_valid_o (b_m_valid),
    .m_ready_i (b_m_ready),
    .m_last_o  (b_m_last)
  );

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({a_m_valid, a_m_last, a_s_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_a: got v/l/r=%b required 000", {a_m_valid, a_m_last, a_s_ready});
    end
    n_checks++;
    if ({b_m_valid, b_m_last, b_s_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_b: got v/l/r=%b required 000", {b_m_valid, b_m_last, b_s_ready});
    end
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({a_m_valid, a_m_last, a_s_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL release_a: got v/l/r=%b required 001", {a_m_valid, a_m_last, a_s_ready});
    end
    n_checks++;
    if ({b_m_valid, b_m_last, b_s_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL release_b: got v/l/r=%b required 001", {b_m_valid, b_m_last, b_s_ready});
    end
  endtask

  task automatic test_single();
    logic [31:0] w;
    logic [10:0] exp_v;
    w = 32'hDDCC_BBAA;
    step();
    a_s_data = w; a_s_valid = 1'b1; a_m_ready = 1'b1;
    #1;
    n_checks++;
    if (a_s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept: got s_ready=%b required 1", a_s_ready);
    end
    step();
    a_s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_v = {1'b1, (k == 3), (k == 3), w[k*8 +: 8]};
      n_checks++;
      if ({a_m_valid, a_m_last, a_s_ready, a_m_data} !== exp_v) begin
        n_fail++;
        $display("FAIL single_beat%0d: got v/l/r/d=%h required %h", k,
                 {a_m_valid, a_m_last, a_s_ready, a_m_data}, exp_v);
      end
      step();
    end
    #1;
    n_checks++;
    if ({a_m_valid, a_m_last, a_s_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL single_end: got v/l/r=%b required 001", {a_m_valid, a_m_last, a_s_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ws;
    logic [10:0] exp_v;
    ws = 64'h8877_6655_4433_2211;
    step();
    a_s_data = ws[31:0]; a_s_valid = 1'b1; a_m_ready = 1'b1;
    step();
    a_s_data = ws[63:32];
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_v = {1'b1, (k % 4 == 3), (k % 4 == 3), ws[k*8 +: 8]};
      n_checks++;
      if ({a_m_valid, a_m_last, a_s_ready, a_m_data} !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got v/l/r/d=%h required %h", k,
                 {a_m_valid, a_m_last, a_s_ready, a_m_data}, exp_v);
      end
      step();
      if (k == 3) a_s_valid = 1'b0;
    end
    #1;
    n_checks++;
    if ({a_m_valid, a_m_last, a_s_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL b2b_end: got v/l/r=%b required 001", {a_m_valid, a_m_last, a_s_ready});
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    logic [10:0] exp_v;
    w = 32'hDDCC_BBAA;
    step();
    a_s_data = w; a_s_valid = 1'b1; a_m_ready = 1'b1;
    step();
    a_s_valid = 1'b0;
    #1;
    n_checks++;
    if ({a_m_valid, a_m_data} !== 9'h1AA) begin
      n_fail++;
      $display("FAIL bp_beat0: got v/d=%h required 1aa", {a_m_valid, a_m_data});
    end
    step();
    a_m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({a_m_valid, a_m_last, a_s_ready, a_m_data} !== 11'h4BB) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got v/l/r/d=%h required 4bb", i,
                 {a_m_valid, a_m_last, a_s_ready, a_m_data});
      end
      step();
    end
    a_m_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      #1;
      exp_v = {1'b1, (k == 3), (k == 3), w[k*8 +: 8]};
      n_checks++;
      if ({a_m_valid, a_m_last, a_s_ready, a_m_data} !== exp_v) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got v/l/r/d=%h required %h", k,
                 {a_m_valid, a_m_last, a_s_ready, a_m_data}, exp_v);
      end
      step();
    end
    #1;
    n_checks++;
    if (a_m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_end: got m_valid=%b required 0", a_m_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    logic [10:0] exp_v;
    w = 32'hDDCC_BBAA;
    step();
    a_s_data = w; a_s_valid = 1'b1; a_m_ready = 1'b1;
    step();
    a_s_valid = 1'b0;
    step();
    step();
    #1;
    n_checks++;
    if ({a_m_valid, a_m_data} !== 9'h1CC) begin
      n_fail++;
      $display("FAIL ar_before: got v/d=%h required 1cc", {a_m_valid, a_m_data});
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({a_m_valid, a_m_last, a_s_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL ar_immediate: got v/l/r=%b required 000", {a_m_valid, a_m_last, a_s_ready});
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({a_m_valid, a_m_last, a_s_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL ar_release: got v/l/r=%b required 001", {a_m_valid, a_m_last, a_s_ready});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (a_m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ar_no_stale%0d: got m_valid=%b data=%h required 0", i, a_m_valid, a_m_data);
      end
    end
    w = 32'h0403_0201;
    a_s_data = w; a_s_valid = 1'b1;
    step();
    a_s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_v = {1'b1, (k == 3), (k == 3), w[k*8 +: 8]};
      n_checks++;
      if ({a_m_valid, a_m_last, a_s_ready, a_m_data} !== exp_v) begin
        n_fail++;
        $display("FAIL ar_new_beat%0d: got v/l/r/d=%h required %h", k,
                 {a_m_valid, a_m_last, a_s_ready, a_m_data}, exp_v);
      end
      step();
    end
  endtask

  task automatic test_source_stall();
    logic [31:0] w1, w2;
    logic [10:0] exp_v;
    w1 = 32'h4433_2211;
    w2 = 32'h8877_6655;
    step();
    a_s_data = w1; a_s_valid = 1'b1; a_m_ready = 1'b1;
    step();
    a_s_valid = 1'b0; a_s_data = w2;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_v = {1'b1, (k == 3), (k == 3), w1[k*8 +: 8]};
      n_checks++;
      if ({a_m_valid, a_m_last, a_s_ready, a_m_data} !== exp_v) begin
        n_fail++;
        $display("FAIL stall_w1_beat%0d: got v/l/r/d=%h required %h", k,
                 {a_m_valid, a_m_last, a_s_ready, a_m_data}, exp_v);
      end
      step();
    end
    for (int g = 0; g < 2; g++) begin
      #1;
      n_checks++;
      if ({a_m_valid, a_m_last, a_s_ready} !== 3'b001) begin
        n_fail++;
        $display("FAIL stall_gap%0d: got v/l/r=%b required 001", g, {a_m_valid, a_m_last, a_s_ready});
      end
      step();
    end
    a_s_valid = 1'b1;
    step();
    a_s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_v = {1'b1, (k == 3), (k == 3), w2[k*8 +: 8]};
      n_checks++;
      if ({a_m_valid, a_m_last, a_s_ready, a_m_data} !== exp_v) begin
        n_fail++;
        $display("FAIL stall_w2_beat%0d: got v/l/r/d=%h required %h", k,
                 {a_m_valid, a_m_last, a_s_ready, a_m_data}, exp_v);
      end
      step();
    end
  endtask

  task automatic test_scale1();
    logic [31:0] sb[$];
    logic [31:0] exp_d;
    for (int c = 0; c < 100; c++) begin
      step();
      if (c < 90) begin
        b_s_valid = 1'($urandom_range(0, 1));
        b_s_data  = $urandom;
        b_m_ready = 1'($urandom_range(0, 1));
      end else begin
        b_s_valid = 1'b0;
        b_m_ready = 1'b1;
      end
      #1;
      n_checks++;
      if (b_m_last !== b_m_valid) begin
        n_fail++;
        $display("FAIL s1_last c=%0d: got m_last=%b required %b", c, b_m_last, b_m_valid);
      end
      if (b_m_valid && b_m_ready) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        n_checks++;
        if (b_m_data !== exp_d) begin
          n_fail++;
          $display("FAIL s1_data c=%0d: got %h required %h", c, b_m_data, exp_d);
        end
      end
      if (b_s_valid && b_s_ready) sb.push_back(b_s_data);
    end
    n_checks++;
    if (sb.size() != 0 || b_m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL s1_drain: got %0d words pending m_valid=%b required 0 and 0", sb.size(), b_m_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_source_stall();
    test_scale1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/stream_downsizer.md
STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

Interface
REQ-001 SHALL have parameter DW, default 8, meaning output beat width in bits (DW >= 1).
REQ-002 SHALL have parameter SCALE, default 4, meaning number of output beats per input word (SCALE >= 1).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port s_data_i, input, DW*SCALE, the wide input word.
REQ-006 SHALL have port s_valid_i, input, 1, the input word is valid.
REQ-007 SHALL have port s_ready_o, output, 1, the block accepts the input word.
REQ-008 SHALL have port m_data_o, output, DW, the narrow output beat.
REQ-009 SHALL have port m_valid_o, output, 1, the output beat is valid.
REQ-010 SHALL have port m_ready_i, input, 1, the sink accepts the output beat.
REQ-011 SHALL have port m_last_o, output, 1, the current beat is the final beat of its input word.

Function
REQ-012 SHALL transfer an input word on a rising edge where s_valid_i && s_ready_o, and an output beat on a rising edge where m_valid_o && m_ready_i.
REQ-013 SHALL capture each accepted input word in an internal holding register; the output SHALL NOT be combinationally driven from s_data_i.
REQ-014 SHALL emit beats least-significant first: beat k (k = 0..SCALE-1) = word bits [k*DW +: DW].
REQ-015 SHALL keep a beat counter of width max(1, clog2(SCALE)), reset to 0, incrementing on each output transfer and wrapping to 0 after beat SCALE-1.
REQ-016 SHALL have two states: EMPTY (m_valid_o=0) and HOLD (m_valid_o=1).
REQ-017 EMPTY -> HOLD SHALL occur on an input transfer, with the counter set to 0.
REQ-018 In HOLD, an output transfer of a non-final beat SHALL advance the counter and stay in HOLD.
REQ-019 In HOLD, an output transfer of the final beat SHALL go to EMPTY if there is no simultaneous input transfer, or stay in HOLD with the new word loaded and the counter at 0 if there is.
REQ-020 SHALL drive s_ready_o = !rst && (state==EMPTY || (m_last_o && m_ready_i)).
REQ-021 SHALL drive m_last_o = (state==HOLD && counter==SCALE-1).
REQ-022 Latency: a word accepted at edge N SHALL present beat 0 on m_data_o with m_valid_o=1 in the cycle after edge N.
REQ-023 Throughput: with s_valid_i and m_ready_i held high, m_valid_o SHALL stay 1 with no bubble, and the block SHALL accept one word every SCALE cycles.
REQ-024 While m_valid_o && !m_ready_i, m_data_o, m_last_o and m_valid_o SHALL hold stable.
REQ-025 When SCALE=1, every beat SHALL be final (m_last_o=1 whenever m_valid_o=1), so the block acts as a one-stage register slice with full throughput.
REQ-026 In EMPTY, m_data_o SHALL be don't-care; the bench SHALL check it only when m_valid_o=1.

Reset
REQ-027 Asserting rst SHALL immediately, without waiting for a clock edge, force state=EMPTY, counter=0, m_valid_o=0, m_last_o=0 and s_ready_o=0.
REQ-028 Reset mid-word SHALL discard the remaining beats, which SHALL never be emitted after reset.
REQ-029 After rst deasserts, s_ready_o SHALL be 1 in the same cycle, and the first accepted word SHALL start at beat 0.

Verification
REQ-030 DW=8, SCALE=4; input 0xDDCCBBAA with m_ready_i=1 -> beats AA, BB, CC, DD on 4 consecutive cycles, m_last_o=1 only on DD, then m_valid_o=0.
REQ-031 Back-to-back words 0x44332211 and 0x88776655 with s_valid_i and m_ready_i held high -> 8 contiguous beats 11..88, the second word accepted on the cycle of beat 44, and no bubble.
REQ-032 Backpressure: m_ready_i=0 for 3 cycles while beat BB is shown -> BB held stable, s_ready_o=0, and the remaining beats follow in order once m_ready_i returns to 1.
REQ-033 rst pulsed asynchronously (between clock edges) after beat BB transfers -> m_valid_o falls immediately, CC and DD are never emitted, and the next word starts at its beat 0.
REQ-034 Source stall: s_valid_i low for 2 cycles between words -> m_valid_o=0 exactly during the gap, with s_ready_o=1 throughout the gap.
REQ-035 SCALE=1, DW=32; random valid/ready toggling -> output sequence equals input sequence and m_last_o equals m_valid_o.
